// File: rtl/mem_wb_stage.sv
// MEM stage of the five-stage MIPS pipeline: data memory with byte/halfword/word
// stores and sign/zero-extended loads, plus the MEM/WB pipeline register.
module mem_wb_stage #(
    parameter int unsigned DM_ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op_3,
    input  logic [5:0]  func_3,
    input  logic [31:0] PC_3,
    input  logic [4:0]  regWA_3,
    input  logic [31:0] ALUout_3,
    input  logic [31:0] MEMin_3,
    output logic [5:0]  op_4,
    output logic [5:0]  func_4,
    output logic [31:0] PC_4,
    output logic [4:0]  regWA_4,
    output logic [31:0] ALUout_4,
    output logic [31:0] memRD_4
);

    localparam int unsigned DEPTH = 1 << DM_ADDR_BITS;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    logic [31:0] mem [DEPTH];

    logic [DM_ADDR_BITS-1:0] idx_c;
    logic [31:0]             rd_word_c;
    logic [15:0]             rd_half_c;
    logic [7:0]              rd_byte_c;
    logic [31:0]             load_c;
    logic [31:0]             store_word_c;
    logic                    store_en_c;

    assign idx_c     = ALUout_3[DM_ADDR_BITS+1:2];
    assign rd_word_c = mem[idx_c];

    // Lane extraction for sub-word loads
    always_comb begin
        rd_half_c = ALUout_3[1] ? rd_word_c[31:16] : rd_word_c[15:0];
        rd_byte_c = rd_word_c[7:0];
        case (ALUout_3[1:0])
            2'd0:    rd_byte_c = rd_word_c[7:0];
            2'd1:    rd_byte_c = rd_word_c[15:8];
            2'd2:    rd_byte_c = rd_word_c[23:16];
            default: rd_byte_c = rd_word_c[31:24];
        endcase
    end

    // Load extension
    always_comb begin
        load_c = '0;
        case (op_3)
            OP_LW:   load_c = rd_word_c;
            OP_LH:   load_c = {{16{rd_half_c[15]}}, rd_half_c};
            OP_LHU:  load_c = {16'h0000, rd_half_c};
            OP_LB:   load_c = {{24{rd_byte_c[7]}}, rd_byte_c};
            OP_LBU:  load_c = {24'h000000, rd_byte_c};
            default: load_c = '0;
        endcase
    end

    // Read-modify-write merge of the store data into the addressed word
    always_comb begin
        store_word_c = rd_word_c;
        store_en_c   = 1'b0;
        case (op_3)
            OP_SW: begin
                store_en_c   = 1'b1;
                store_word_c = MEMin_3;
            end
            OP_SH: begin
                store_en_c = 1'b1;
                if (ALUout_3[1]) store_word_c[31:16] = MEMin_3[15:0];
                else             store_word_c[15:0]  = MEMin_3[15:0];
            end
            OP_SB: begin
                store_en_c = 1'b1;
                case (ALUout_3[1:0])
                    2'd0:    store_word_c[7:0]   = MEMin_3[7:0];
                    2'd1:    store_word_c[15:8]  = MEMin_3[7:0];
                    2'd2:    store_word_c[23:16] = MEMin_3[7:0];
                    default: store_word_c[31:24] = MEMin_3[7:0];
                endcase
            end
            default: begin
                store_en_c   = 1'b0;
                store_word_c = rd_word_c;
            end
        endcase
    end

    // Pipeline register and memory update; reset also clears the whole array
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_4     <= '0;
            func_4   <= '0;
            PC_4     <= '0;
            regWA_4  <= '0;
            ALUout_4 <= '0;
            memRD_4  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[DM_ADDR_BITS'(i)] <= '0;
            end
        end else begin
            op_4     <= op_3;
            func_4   <= func_3;
            PC_4     <= PC_3;
            regWA_4  <= regWA_3;
            ALUout_4 <= ALUout_3;
            memRD_4  <= load_c;
            if (store_en_c) begin
                mem[idx_c] <= store_word_c;
            end
        end
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM stage of the five-stage MIPS pipeline, including the MEM/WB pipeline register.
- Owns the data memory. Performs word, halfword and byte stores, and word, halfword and byte loads with sign or zero extension.
- Registers the instruction's control fields so the write-back stage receives op/func/PC/regWA/ALU result/load data one cycle after MEM.
- Sits between the EX/MEM register (stage-3 signals) and the write-back mux (stage-4 signals).

Parameters:
- DM_ADDR_BITS, 10, word-address width; memory depth = 2^DM_ADDR_BITS words (4 KiB at default).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (reset==0 resets on the next rising clk edge).
- op_3  input  6  opcode of the instruction in MEM.
- func_3  input  6  funct field of the instruction in MEM.
- PC_3  input  32  PC of the instruction in MEM.
- regWA_3  input  5  destination register number.
- ALUout_3  input  32  ALU result; the byte address for loads and stores.
- MEMin_3  input  32  store data (rt value, already forwarded).
- op_4  output  6  registered op_3.
- func_4  output  6  registered func_3.
- PC_4  output  32  registered PC_3.
- regWA_4  output  5  registered regWA_3.
- ALUout_4  output  32  registered ALUout_3.
- memRD_4  output  32  extended load data; 0 for non-load instructions.

Behaviour:
- Memory array and word index:
  - Array: 2^DM_ADDR_BITS x 32-bit words.
  - Word index = ALUout_3[DM_ADDR_BITS+1:2]. Higher address bits are ignored, so addresses wrap.
- Reset (reset==0 at a clk edge):
  - All stage-4 outputs go to 0. op=0, func=0 is a nop.
  - Every memory word is cleared to 0.
  - Any store presented in that cycle is dropped.
  - Reset mid-operation discards the in-flight instruction.
- Pipeline register:
  - Each rising edge with reset==1 latches op/func/PC/regWA/ALUout from stage 3 to stage 4.
  - Latency is exactly 1 cycle. There is no stall or flush input: the MEM/WB register never freezes.
- Stores update the array at the same edge as the pipeline latch. Lane selection by op_3:
  - sw (0x2B): whole word written with MEMin_3. ALUout_3[1:0] is ignored (word-aligned by truncation).
  - sh (0x29): halfword lane ALUout_3[1] (0 = bits 15:0, 1 = bits 31:16) written with MEMin_3[15:0]. Other lanes are unchanged. ALUout_3[0] is ignored.
  - sb (0x28): byte lane ALUout_3[1:0] (lane k = bits 8k+7:8k) written with MEMin_3[7:0]. Other lanes are unchanged.
- Loads:
  - The word at the index is read combinationally from the array contents before this edge.
  - The extended result is registered into memRD_4 at the edge.
  - Extension and lane selection by op_3:
    - lw (0x23): full word.
    - lh (0x21): sign-extended halfword at lane ALUout_3[1].
    - lhu (0x25): zero-extended halfword at lane ALUout_3[1].
    - lb (0x20): sign-extended byte at lane ALUout_3[1:0].
    - lbu (0x24): zero-extended byte at lane ALUout_3[1:0].
  - Any other opcode: memRD_4 <= 0.
- Ordering and hazards:
  - Store followed next cycle by a load to the same word: the load returns the newly stored data, because the array is updated at the earlier edge.
  - Load and store can never be in MEM in the same cycle.
- Non-memory opcodes never modify the array.
- No exceptions or alignment traps. Misaligned addresses are truncated as described above.

Test Plan:
- Reset: hold reset=0 for 2 edges with op_3=0x2B, ALUout_3=0, MEMin_3=0xDEADBEEF. Then release and issue lw at address 0 -> memRD_4=0 and all stage-4 outputs 0 while in reset; the store was dropped.
- Word round trip: sw 0x12345678 at address 0x10, then next cycle lw at 0x10 -> memRD_4=0x12345678 one cycle after lw is presented; PC_4/regWA_4/ALUout_4 match the lw's stage-3 values.
- Byte lanes: sw 0 at 0x20, then sb MEMin_3=0xAB85 at 0x23 -> lw 0x20 gives 0x85000000; lb 0x23 gives 0xFFFFFF85; lbu 0x23 gives 0x00000085.
- Halfword: sw 0 at 0x30, then sh MEMin_3=0x00019ABC at 0x32 -> lw gives 0x9ABC0000; lh 0x32 gives 0xFFFF9ABC; lhu 0x32 gives 0x00009ABC; lh 0x30 gives 0.
- Wrap and pass-through:
  - sw 0x55 at address 0x1000 (default depth), then lw at 0x0 -> 0x55.
  - An add (op=0, func=0x20, ALUout_3=7) -> memRD_4=0, ALUout_4=7, memory unchanged.
